// File: rtl/i2c_poll_sched.sv
// Shares one i2c_master across four sensor buses. It polls one register per enabled channel
// each round and gives one-shot host transactions priority. m_rw: 1 = read, 0 = write.
module i2c_poll_sched #(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned TO_CYC   = 4096
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                en,
    input  logic [3:0]          ch_mask,
    input  logic [2:0]          dev_adr,
    input  logic [7:0]          poll_reg,
    input  logic [PERIOD_W-1:0] period,
    input  logic                host_req,
    input  logic                host_rw,
    input  logic [1:0]          host_ch,
    input  logic [2:0]          host_adr,
    input  logic [7:0]          host_reg,
    input  logic [7:0]          host_wdata,
    output logic                host_ack,
    output logic [7:0]          host_rdata,
    output logic                m_start,
    output logic                m_rw,
    output logic [1:0]          m_ch,
    output logic [2:0]          m_adr,
    output logic [7:0]          m_reg,
    output logic [7:0]          m_wdata,
    input  logic                m_end,
    input  logic [7:0]          m_rdata,
    input  logic [1:0]          res_sel,
    output logic [7:0]          res_data,
    output logic [3:0]          res_valid,
    output logic [3:0]          err,
    output logic                busy
);

    localparam int unsigned TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SEL,
        S_RUN,
        S_GAP
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] wait_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [2:0]          ptr;
    logic                round;
    logic                owner_host;
    logic [3:0][7:0]     result;
    logic                nxt_found;
    logic [1:0]          nxt_ch;
    logic                poll_on;

    assign res_data = result[res_sel];
    assign poll_on  = en && (ch_mask != 4'b0000);

    // Lowest enabled channel at or above the round pointer.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (ch_mask[n] && (3'(n) >= ptr)) begin
                nxt_found = 1'b1;
                nxt_ch    = 2'(n);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            to_cnt     <= '0;
            ptr        <= 3'd0;
            round      <= 1'b0;
            owner_host <= 1'b0;
            result     <= '0;
            res_valid  <= 4'b0000;
            err        <= 4'b0000;
            host_ack   <= 1'b0;
            host_rdata <= 8'h00;
            m_start    <= 1'b0;
            m_rw       <= 1'b0;
            m_ch       <= 2'd0;
            m_adr      <= 3'd0;
            m_reg      <= 8'h00;
            m_wdata    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host_req) begin
                        state <= S_SEL;
                        busy  <= 1'b1;
                    end else if (poll_on) begin
                        state <= S_SEL;
                        busy  <= 1'b1;
                        round <= 1'b1;
                        ptr   <= 3'd0;
                    end
                end
                S_SEL: begin
                    if (host_req) begin
                        m_rw       <= host_rw;
                        m_ch       <= host_ch;
                        m_adr      <= host_adr;
                        m_reg      <= host_reg;
                        m_wdata    <= host_wdata;
                        owner_host <= 1'b1;
                        to_cnt     <= '0;
                        m_start    <= 1'b1;
                        state      <= S_RUN;
                    end else if (round && nxt_found) begin
                        m_rw       <= 1'b1;
                        m_ch       <= nxt_ch;
                        m_adr      <= dev_adr;
                        m_reg      <= poll_reg;
                        m_wdata    <= 8'h00;
                        owner_host <= 1'b0;
                        ptr        <= {1'b0, nxt_ch} + 3'd1;
                        to_cnt     <= '0;
                        m_start    <= 1'b1;
                        state      <= S_RUN;
                    end else if (round) begin
                        wait_cnt <= period;
                        state    <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (m_end) begin
                        m_start  <= 1'b0;
                        host_ack <= owner_host;
                        state    <= S_GAP;
                        if (m_rw) begin
                            if (owner_host) begin
                                host_rdata <= m_rdata;
                                if (m_reg == poll_reg) begin
                                    result[m_ch] <= m_rdata;
                                end
                            end else begin
                                result[m_ch]    <= m_rdata;
                                res_valid[m_ch] <= 1'b1;
                                err[m_ch]       <= 1'b0;
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // Master never answered: abandon the transfer and flag the bus.
                        m_start   <= 1'b0;
                        host_ack  <= owner_host;
                        err[m_ch] <= 1'b1;
                        state     <= S_GAP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_GAP: begin
                    if (host_req || (round && poll_on)) begin
                        state <= S_SEL;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        round <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A host request leaves the pointer past the last channel, so SEL restarts the wait.
                    if (host_req) begin
                        state <= S_SEL;
                    end else if (wait_cnt == '0) begin
                        if (poll_on) begin
                            ptr   <= 3'd0;
                            state <= S_SEL;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            round <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - PERIOD_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    m_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_poll_sched.sv
// Bench for i2c_poll_sched: a transaction-level model (expected queue + result bank)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_i2c_poll_sched;

    localparam int PERIOD_W = 16;
    localparam int TO_CYC   = 64;

    logic                CLK = 1'b0;
    logic                RES = 1'b0;
    logic                en = 1'b0;
    logic [3:0]          ch_mask = 4'b0000;
    logic [2:0]          dev_adr = 3'd0;
    logic [7:0]          poll_reg = 8'h00;
    logic [PERIOD_W-1:0] period = '0;
    logic                host_req = 1'b0;
    logic                host_rw = 1'b0;
    logic [1:0]          host_ch = 2'd0;
    logic [2:0]          host_adr = 3'd0;
    logic [7:0]          host_reg = 8'h00;
    logic [7:0]          host_wdata = 8'h00;
    logic                host_ack;
    logic [7:0]          host_rdata;
    logic                m_start;
    logic                m_rw;
    logic [1:0]          m_ch;
    logic [2:0]          m_adr;
    logic [7:0]          m_reg;
    logic [7:0]          m_wdata;
    logic                m_end;
    logic [7:0]          m_rdata;
    logic [1:0]          res_sel = 2'd0;
    logic [7:0]          res_data;
    logic [3:0]          res_valid;
    logic [3:0]          err;
    logic                busy;

    i2c_poll_sched #(.PERIOD_W(PERIOD_W), .TO_CYC(TO_CYC)) dut (
        .CLK(CLK), .RES(RES), .en(en), .ch_mask(ch_mask), .dev_adr(dev_adr),
        .poll_reg(poll_reg), .period(period), .host_req(host_req), .host_rw(host_rw),
        .host_ch(host_ch), .host_adr(host_adr), .host_reg(host_reg), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .m_start(m_start), .m_rw(m_rw),
        .m_ch(m_ch), .m_adr(m_adr), .m_reg(m_reg), .m_wdata(m_wdata), .m_end(m_end),
        .m_rdata(m_rdata), .res_sel(res_sel), .res_data(res_data), .res_valid(res_valid),
        .err(err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       host;
        logic       rw;
        logic [1:0] ch;
        logic [2:0] adr;
        logic [7:0] rg;
        logic [7:0] wd;
    } txn_t;

    int   checks = 0;
    int   failures = 0;
    txn_t q[$];
    txn_t cur = '0;
    bit   started = 0;
    logic prev_ms = 1'b0;

    logic [7:0] exp_res [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [3:0] exp_valid = 4'b0000;
    logic [3:0] exp_err = 4'b0000;
    logic [7:0] exp_hrdata = 8'h00;
    logic       exp_ack = 1'b0;
    logic       exp_drop = 1'b0;
    int         run_cnt = 0;

    // Master model controls
    int         m_lat = 20;
    logic [3:0] hang = 4'b0000;
    logic       spur = 1'b0;
    logic [7:0] rd_tab [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         mcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic txn_t poll_txn(input logic [1:0] c);
        return '{host: 1'b0, rw: 1'b1, ch: c, adr: dev_adr, rg: poll_reg, wd: 8'h00};
    endfunction

    // Bounded wait on a negedge-sampled condition: 0 m_start low, 1 m_start high,
    // 2 queue drained and idle master, 3 busy low, 4 host_ack, 5 queue size == arg.
    task automatic wait_for(input int what, input int arg, input int budget, input string nm);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            case (what)
                0: ok = (m_start === 1'b0);
                1: ok = (m_start === 1'b1);
                2: ok = (q.size() == 0) && (m_start === 1'b0);
                3: ok = (busy === 1'b0);
                4: ok = (host_ack === 1'b1);
                default: ok = (q.size() == arg);
            endcase
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: wait expired after %0d cycles", nm, budget);
        end
    endtask

    task automatic count_level(input logic v, output int n);
        n = 0;
        while (m_start === v && n < 5000) begin
            n++;
            @(negedge CLK);
        end
    endtask

    // Master: answers m_lat cycles after m_start rises unless the bus is hung.
    initial begin
        m_end   = 1'b0;
        m_rdata = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            m_end = spur;
            if (m_start === 1'b1) begin
                mcnt++;
                if (mcnt == m_lat && !hang[m_ch]) begin
                    m_end   = 1'b1;
                    m_rdata = rd_tab[m_ch];
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Model: reacts to the transaction the bench expects to be on the bus.
    always @(posedge CLK) begin
        exp_ack  <= 1'b0;
        exp_drop <= 1'b0;
        if (!RES) begin
            exp_res    <= '{8'h00, 8'h00, 8'h00, 8'h00};
            exp_valid  <= 4'b0000;
            exp_err    <= 4'b0000;
            exp_hrdata <= 8'h00;
            exp_drop   <= 1'b1;
            run_cnt    <= 0;
        end else if (m_start === 1'b1) begin
            if (m_end === 1'b1) begin
                exp_drop <= 1'b1;
                exp_ack  <= cur.host;
                run_cnt  <= 0;
                if (cur.rw) begin
                    if (cur.host) begin
                        exp_hrdata <= m_rdata;
                        if (cur.rg == poll_reg) exp_res[cur.ch] <= m_rdata;
                    end else begin
                        exp_res[cur.ch]   <= m_rdata;
                        exp_valid[cur.ch] <= 1'b1;
                        exp_err[cur.ch]   <= 1'b0;
                    end
                end
            end else if (run_cnt + 1 == TO_CYC) begin
                exp_drop         <= 1'b1;
                exp_ack          <= cur.host;
                exp_err[cur.ch]  <= 1'b1;
                run_cnt          <= 0;
            end else begin
                run_cnt <= run_cnt + 1;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge CLK) begin
        if (started) begin
            chk("res_valid", 32'(res_valid), 32'(exp_valid));
            chk("err", 32'(err), 32'(exp_err));
            chk("res_data", 32'(res_data), 32'(exp_res[res_sel]));
            chk("host_ack", 32'(host_ack), 32'(exp_ack));
            chk("host_rdata", 32'(host_rdata), 32'(exp_hrdata));
            if (exp_drop) chk("m_start_drop", 32'(m_start), 32'd0);
            if (m_start === 1'b1) chk("busy_in_run", 32'(busy), 32'd1);
            if (m_start === 1'b1 && prev_ms !== 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_txn: got start ch=%0d expected none at %0t", m_ch, $time);
                    cur = '0;
                end else begin
                    cur = q.pop_front();
                    chk("txn_rw", 32'(m_rw), 32'(cur.rw));
                    chk("txn_ch", 32'(m_ch), 32'(cur.ch));
                    chk("txn_adr", 32'(m_adr), 32'(cur.adr));
                    chk("txn_reg", 32'(m_reg), 32'(cur.rg));
                    chk("txn_wdata", 32'(m_wdata), 32'(cur.wd));
                end
            end else if (m_start === 1'b1) begin
                chk("stable_fields", 32'({m_rw, m_ch, m_adr, m_reg, m_wdata}),
                    32'({cur.rw, cur.ch, cur.adr, cur.rg, cur.wd}));
            end
            prev_ms = m_start;
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_fields", 32'({m_rw, m_ch, m_adr, m_reg, m_wdata}), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        started = 1;
        RES = 1'b1;

        // Two-channel rounds with a 10-cycle period.
        dev_adr = 3'd4; poll_reg = 8'h10; period = 16'd10; ch_mask = 4'b0101;
        rd_tab[0] = 8'hA5; rd_tab[1] = 8'h5A; rd_tab[2] = 8'h3C;
        q.push_back(poll_txn(2'd0)); q.push_back(poll_txn(2'd2));
        q.push_back(poll_txn(2'd0)); q.push_back(poll_txn(2'd2));
        en = 1'b1;
        wait_for(1, 0, 50, "r1_start");
        wait_for(0, 0, 100, "r1_ch0_end");
        count_level(1'b0, n);
        chk("gap_in_round", 32'(n), 32'd2);
        wait_for(0, 0, 100, "r1_ch2_end");
        count_level(1'b0, n);
        chk("gap_between_rounds", 32'(n), 32'(int'(period) + 4));
        wait_for(2, 0, 200, "r2_drain");
        en = 1'b0;
        wait_for(3, 0, 100, "r2_idle");
        chk("s1_res_valid", 32'(res_valid), 32'h5);
        res_sel = 2'd0;
        @(negedge CLK);
        chk("s1_result0", 32'(res_data), 32'hA5);
        res_sel = 2'd2;
        @(negedge CLK);
        chk("s1_result2", 32'(res_data), 32'h3C);

        // Host write arrives during the ch0 poll and is granted before ch2.
        rd_tab[0] = 8'h11; rd_tab[2] = 8'h22;
        q.push_back(poll_txn(2'd0));
        q.push_back('{host: 1'b1, rw: 1'b0, ch: 2'd3, adr: 3'd5, rg: 8'h01, wd: 8'h60});
        q.push_back(poll_txn(2'd2));
        en = 1'b1;
        wait_for(1, 0, 50, "s2_start");
        host_rw = 1'b0; host_ch = 2'd3; host_adr = 3'd5; host_reg = 8'h01; host_wdata = 8'h60;
        host_req = 1'b1;
        wait_for(4, 0, 200, "s2_ack");
        host_req = 1'b0;
        wait_for(2, 0, 200, "s2_drain");
        en = 1'b0;
        wait_for(3, 0, 100, "s2_idle");
        res_sel = 2'd0;
        @(negedge CLK);
        chk("s2_result0", 32'(res_data), 32'h11);

        // ch1 hangs and times out; the next round polls it successfully.
        ch_mask = 4'b0110; period = 16'd3; hang = 4'b0010; rd_tab[2] = 8'h44;
        q.push_back(poll_txn(2'd1)); q.push_back(poll_txn(2'd2));
        q.push_back(poll_txn(2'd1)); q.push_back(poll_txn(2'd2));
        en = 1'b1;
        wait_for(1, 0, 50, "s3_start");
        count_level(1'b1, n);
        chk("timeout_len", 32'(n), 32'(TO_CYC));
        wait_for(5, 2, 50, "s3_ch2");
        hang = 4'b0000;
        chk("s3_err_set", 32'(err), 32'h2);
        wait_for(2, 0, 300, "s3_drain");
        en = 1'b0;
        wait_for(3, 0, 100, "s3_idle");
        chk("s3_err_clear", 32'(err), 32'h0);
        chk("s3_res_valid", 32'(res_valid), 32'h7);

        // Host read of the poll register also refreshes the result bank.
        rd_tab[2] = 8'h77;
        q.push_back('{host: 1'b1, rw: 1'b1, ch: 2'd2, adr: 3'd6, rg: 8'h10, wd: 8'h00});
        host_rw = 1'b1; host_ch = 2'd2; host_adr = 3'd6; host_reg = 8'h10; host_wdata = 8'h00;
        host_req = 1'b1;
        wait_for(4, 0, 100, "s4_ack");
        host_req = 1'b0;
        wait_for(3, 0, 20, "s4_idle");
        chk("s4_host_rdata", 32'(host_rdata), 32'h77);
        res_sel = 2'd2;
        @(negedge CLK);
        chk("s4_result2", 32'(res_data), 32'h77);
        chk("s4_res_valid", 32'(res_valid), 32'h7);

        // en dropped mid-transaction; then empty mask keeps the block idle.
        ch_mask = 4'b0001;
        q.push_back(poll_txn(2'd0));
        en = 1'b1;
        wait_for(1, 0, 50, "s5_start");
        en = 1'b0;
        wait_for(0, 0, 100, "s5_end");
        chk("s5_busy_gap", 32'(busy), 32'd1);
        @(negedge CLK);
        chk("s5_busy_idle", 32'(busy), 32'd0);
        ch_mask = 4'b0000; en = 1'b1;
        repeat (20) @(negedge CLK);
        chk("s5_mask0_idle", 32'(busy), 32'd0);

        // Reset while the master is running; spurious m_end afterwards is ignored.
        ch_mask = 4'b0001;
        q.push_back(poll_txn(2'd0));
        wait_for(1, 0, 50, "s6_start");
        repeat (3) @(negedge CLK);
        RES = 1'b0; en = 1'b0;
        @(negedge CLK);
        chk("s6_m_start", 32'(m_start), 32'd0);
        chk("s6_res_valid", 32'(res_valid), 32'd0);
        chk("s6_err", 32'(err), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        RES = 1'b1; spur = 1'b1;
        repeat (5) @(negedge CLK);
        spur = 1'b0;
        chk("s6_spur_valid", 32'(res_valid), 32'd0);
        chk("s6_spur_busy", 32'(busy), 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
